aes_master_ctrl: RTL and testbench
==================================

// Module: aes_master_ctrl
// PURPOSE
//  Sequencer in front of encryptor + key_repository. Arbitrates key-load and
//  plaintext requests, issues one-cycle start_exp/start_enc pulses and drives
//  the keylength one-hots. Blocks encryption until a valid expanded key exists
//  and detects stalled engines via a watchdog. Replaces the combinational
//  dv->start pass-through at aes_enc top level.
// PARAMETERS
//  TIMEOUT  1024  max cycles in EXP_WAIT/ENC_WAIT before abort (>=4)
//  CNT_W    16    width of blocks_done counter
// PORTS
//  mclk           in   1      master clock, all logic on rising edge
//  arst_n         in   1      reset, synchronous, active-low
//  key_req        in   1      key-load request; held high until key_ack
//  key_len        in   2      00=128, 01=192, 10=256, 11=illegal; valid with key_req
//  key_ack        out  1      1-cycle pulse: key request consumed
//  pt_req         in   1      plaintext request; held high until pt_ack
//  pt_ack         out  1      1-cycle pulse: plaintext request consumed
//  start_exp      out  1      1-cycle start pulse to key_repository
//  start_enc      out  1      1-cycle start pulse to encryptor
//  keylength128   out  1      registered one-hot key length, 128-bit
//  keylength192   out  1      registered one-hot key length, 192-bit
//  keylength256   out  1      registered one-hot key length, 256-bit
//  busy_exp       in   1      key_repository busy
//  busy_enc       in   1      encryptor busy
//  ciphertext_dv  in   1      encryptor output valid
//  key_valid      out  1      expanded key present and usable
//  ctrl_busy      out  1      state != IDLE
//  err            out  1      1-cycle pulse on any error; err_code valid same cycle
//  err_code       out  2      01=illegal key_len, 10=pt with no key, 11=timeout; sticky until next err
//  blocks_done    out  CNT_W  completed encryptions, wraps to 0 at 2^CNT_W
// BEHAVIOUR
//  Reset (arst_n=0 at edge): state=IDLE. All outputs 0, except keylength128=1.
//   key_valid=0, err_code=00, blocks_done=0. Reset overrides any in-flight operation.
//  All outputs registered. FSM: IDLE, EXP_ARM, EXP_GUARD, EXP_WAIT,
//   ENC_ARM, ENC_GUARD, ENC_WAIT.
//  IDLE arbitration, evaluated each cycle:
//   - key_req has priority over pt_req when both are high.
//   - key_req, key_len!=11: latch key_len into keylength*, clear key_valid,
//     go to EXP_ARM.
//   - key_req, key_len==11: key_ack+err, err_code=01. Stay in IDLE;
//     key_valid and keylength* unchanged.
//   - pt_req, key_valid=1: go to ENC_ARM.
//   - pt_req, key_valid=0: pt_ack+err, err_code=10. Stay in IDLE; no start.
//  EXP_ARM: start_exp=1 and key_ack=1 for exactly this cycle (request seen at t
//   -> ack/start at t+1); next state EXP_GUARD. Cipherkey must be stable
//   through this cycle.
//  EXP_GUARD: busy_exp ignored for one cycle (engine busy-rise latency);
//   next state EXP_WAIT.
//  EXP_WAIT: busy_exp==0 -> key_valid=1, go to IDLE.
//  ENC_ARM: start_enc=1 and pt_ack=1 for this cycle; next state ENC_GUARD.
//  ENC_GUARD: one-cycle guard; next state ENC_WAIT.
//  ENC_WAIT: ciphertext_dv==1 or busy_enc==0 -> blocks_done+1 (mod 2^CNT_W),
//   go to IDLE.
//  Watchdog: counter clears on entry to either WAIT state.
//   - Reaching TIMEOUT cycles: err, err_code=11, key_valid=0, go to IDLE,
//     blocks_done unchanged.
//  Requests arriving outside IDLE are not acked. They wait; the requester must
//   hold req. Min spacing between accepts is 4 cycles.
//  keylength* change only on a legal key accept, never while in ENC_* states.
//  Back-to-back: a request pending when a WAIT state exits is arbitrated in the
//   first IDLE cycle (one IDLE cycle minimum).
// TESTING
//  1. Reset, key_req=1, key_len=10, busy_exp high 3 cycles -> key_ack+start_exp
//     at t+1; keylength256=1; key_valid=1 once busy_exp falls.
//  2. key_valid=1, pt_req=1, ciphertext_dv at 12th cycle -> single start_enc
//     pulse, pt_ack; blocks_done 0->1, back to IDLE.
//  3. key_req and pt_req rise same cycle -> expansion first, then encryption
//     with the new key; exactly one ack each.
//  4. After reset, pt_req=1 -> pt_ack+err, err_code=10, no start_enc.
//     key_req with key_len=11 -> err_code=01, key_valid unchanged.
//  5. TIMEOUT=8, busy_enc stuck at 1 -> err, err_code=11 after 8 cycles in
//     ENC_WAIT; key_valid=0. arst_n=0 mid-ENC_WAIT -> all reset values next edge.
//  6. CNT_W=2: five encryptions -> blocks_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/aes_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_master_ctrl : sequencer in front of key expansion and block encryption
// Rev 1.0
// ---------------------------------------------------------------------------
module aes_master_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             mclk,
  input  logic             arst_n,
  input  logic             key_req,
  input  logic [1:0]       key_len,
  output logic             key_ack,
  input  logic             pt_req,
  output logic             pt_ack,
  output logic             start_exp,
  output logic             start_enc,
  output logic             keylength128,
  output logic             keylength192,
  output logic             keylength256,
  input  logic             busy_exp,
  input  logic             busy_enc,
  input  logic             ciphertext_dv,
  output logic             key_valid,
  output logic             ctrl_busy,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] blocks_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EXP_ARM   = 3'd1,
    EXP_GUARD = 3'd2,
    EXP_WAIT  = 3'd3,
    ENC_ARM   = 3'd4,
    ENC_GUARD = 3'd5,
    ENC_WAIT  = 3'd6
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             key_ack_q, key_ack_d;
  logic             pt_ack_q, pt_ack_d;
  logic             start_exp_q, start_exp_d;
  logic             start_enc_q, start_enc_d;
  logic [2:0]       kl_q, kl_d;
  logic             key_valid_q, key_valid_d;
  logic             ctrl_busy_q, ctrl_busy_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] blocks_q, blocks_d;
  logic             wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    key_ack_d   = 1'b0;
    pt_ack_d    = 1'b0;
    start_exp_d = 1'b0;
    start_enc_d = 1'b0;
    kl_d        = kl_q;
    key_valid_d = key_valid_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    blocks_d    = blocks_q;

    case (state_q)
      IDLE: begin
        // A request acked from IDLE in the previous cycle is still held high
        // by its requester; skip arbitration for that one cycle.
        if (!(key_ack_q || pt_ack_q)) begin
          if (key_req) begin
            key_ack_d = 1'b1;
            if (key_len == 2'b11) begin
              err_d      = 1'b1;
              err_code_d = 2'b01;
            end else begin
              start_exp_d = 1'b1;
              key_valid_d = 1'b0;
              state_d     = EXP_ARM;
              case (key_len)
                2'b00:   kl_d = 3'b001;
                2'b01:   kl_d = 3'b010;
                default: kl_d = 3'b100;
              endcase
            end
          end else if (pt_req) begin
            pt_ack_d = 1'b1;
            if (key_valid_q) begin
              start_enc_d = 1'b1;
              state_d     = ENC_ARM;
            end else begin
              err_d      = 1'b1;
              err_code_d = 2'b10;
            end
          end
        end
      end
      EXP_ARM:   state_d = EXP_GUARD;
      EXP_GUARD: begin
        state_d = EXP_WAIT;
        wd_d    = '0;
      end
      EXP_WAIT: begin
        if (!busy_exp) begin
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (wd_expired) begin
          err_d       = 1'b1;
          err_code_d  = 2'b11;
          key_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ENC_ARM:   state_d = ENC_GUARD;
      ENC_GUARD: begin
        state_d = ENC_WAIT;
        wd_d    = '0;
      end
      ENC_WAIT: begin
        if (ciphertext_dv || !busy_enc) begin
          blocks_d = blocks_q + CNT_W'(1);
          state_d  = IDLE;
        end else if (wd_expired) begin
          err_d       = 1'b1;
          err_code_d  = 2'b11;
          key_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ctrl_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge mclk) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      key_ack_q   <= 1'b0;
      pt_ack_q    <= 1'b0;
      start_exp_q <= 1'b0;
      start_enc_q <= 1'b0;
      kl_q        <= 3'b001;
      key_valid_q <= 1'b0;
      ctrl_busy_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      blocks_q    <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      key_ack_q   <= key_ack_d;
      pt_ack_q    <= pt_ack_d;
      start_exp_q <= start_exp_d;
      start_enc_q <= start_enc_d;
      kl_q        <= kl_d;
      key_valid_q <= key_valid_d;
      ctrl_busy_q <= ctrl_busy_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      blocks_q    <= blocks_d;
    end
  end

  assign key_ack      = key_ack_q;
  assign pt_ack       = pt_ack_q;
  assign start_exp    = start_exp_q;
  assign start_enc    = start_enc_q;
  assign keylength128 = kl_q[0];
  assign keylength192 = kl_q[1];
  assign keylength256 = kl_q[2];
  assign key_valid    = key_valid_q;
  assign ctrl_busy    = ctrl_busy_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign blocks_done  = blocks_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_master_ctrl : directed bench; b_* instance uses default parameters,
// s_* instance uses TIMEOUT=8, CNT_W=2. Rev 1.0
// ---------------------------------------------------------------------------
module tb_aes_master_ctrl;

  logic mclk = 1'b0;
  logic arst_n, key_req, pt_req, busy_exp, busy_enc, ciphertext_dv;
  logic [1:0] key_len;

  logic b_key_ack, b_pt_ack, b_start_exp, b_start_enc, b_kl128, b_kl192, b_kl256;
  logic b_key_valid, b_ctrl_busy, b_err;
  logic [1:0] b_err_code;
  logic [15:0] b_blocks;
  logic s_key_ack, s_pt_ack, s_start_exp, s_start_enc, s_kl128, s_kl192, s_kl256;
  logic s_key_valid, s_ctrl_busy, s_err;
  logic [1:0] s_err_code;
  logic [1:0] s_blocks;

  int n_cmp = 0;
  int n_err = 0;
  logic sel = 1'b0;
  logic m_key_ack, m_pt_ack, m_ctrl_busy;

  assign m_key_ack   = sel ? s_key_ack   : b_key_ack;
  assign m_pt_ack    = sel ? s_pt_ack    : b_pt_ack;
  assign m_ctrl_busy = sel ? s_ctrl_busy : b_ctrl_busy;

  always #5 mclk = ~mclk;

  aes_master_ctrl u_big (
    .mclk(mclk), .arst_n(arst_n), .key_req(key_req), .key_len(key_len),
    .key_ack(b_key_ack), .pt_req(pt_req), .pt_ack(b_pt_ack),
    .start_exp(b_start_exp), .start_enc(b_start_enc),
    .keylength128(b_kl128), .keylength192(b_kl192), .keylength256(b_kl256),
    .busy_exp(busy_exp), .busy_enc(busy_enc), .ciphertext_dv(ciphertext_dv),
    .key_valid(b_key_valid), .ctrl_busy(b_ctrl_busy), .err(b_err),
    .err_code(b_err_code), .blocks_done(b_blocks)
  );

  aes_master_ctrl #(.TIMEOUT(8), .CNT_W(2)) u_small (
    .mclk(mclk), .arst_n(arst_n), .key_req(key_req), .key_len(key_len),
    .key_ack(s_key_ack), .pt_req(pt_req), .pt_ack(s_pt_ack),
    .start_exp(s_start_exp), .start_enc(s_start_enc),
    .keylength128(s_kl128), .keylength192(s_kl192), .keylength256(s_kl256),
    .busy_exp(busy_exp), .busy_enc(busy_enc), .ciphertext_dv(ciphertext_dv),
    .key_valid(s_key_valid), .ctrl_busy(s_ctrl_busy), .err(s_err),
    .err_code(s_err_code), .blocks_done(s_blocks)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge mclk);
  endtask

  task automatic do_reset();
    arst_n = 1'b0; key_req = 1'b0; pt_req = 1'b0; key_len = 2'b00;
    busy_exp = 1'b0; busy_enc = 1'b0; ciphertext_dv = 1'b0;
    step(); step();
    arst_n = 1'b1;
  endtask

  task automatic do_key(input logic [1:0] len);
    logic ok;
    ok = 1'b0;
    key_len = len; key_req = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (m_key_ack) ok = 1'b1;
    end
    key_req = 1'b0;
    chk("key_ack_seen", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (!m_ctrl_busy) ok = 1'b1;
    end
    chk("key_done", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_enc();
    logic ok;
    ok = 1'b0;
    pt_req = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (m_pt_ack) ok = 1'b1;
    end
    pt_req = 1'b0;
    chk("pt_ack_seen", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (!m_ctrl_busy) ok = 1'b1;
    end
    chk("enc_done", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n_kack, n_pack, n_sexp, n_senc, t_exp, t_enc;
    logic [1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;

    // Reset values
    do_reset();
    chk("rst_kl128", {31'd0, b_kl128}, 32'd1);
    chk("rst_kl256", {31'd0, b_kl256}, 32'd0);
    chk("rst_key_valid", {31'd0, b_key_valid}, 32'd0);
    chk("rst_busy", {31'd0, b_ctrl_busy}, 32'd0);
    chk("rst_err_code", {30'd0, b_err_code}, 32'd0);
    chk("rst_blocks", {16'd0, b_blocks}, 32'd0);

    // 256-bit key load, busy_exp high for three cycles
    key_req = 1'b1; key_len = 2'b10;
    step();
    chk("t1_key_ack", {31'd0, b_key_ack}, 32'd1);
    chk("t1_start_exp", {31'd0, b_start_exp}, 32'd1);
    chk("t1_kl256", {31'd0, b_kl256}, 32'd1);
    chk("t1_kl128", {31'd0, b_kl128}, 32'd0);
    chk("t1_busy", {31'd0, b_ctrl_busy}, 32'd1);
    key_req = 1'b0; busy_exp = 1'b1;
    step();
    chk("t1_ack_pulse", {31'd0, b_key_ack}, 32'd0);
    chk("t1_sexp_pulse", {31'd0, b_start_exp}, 32'd0);
    step(); step();
    chk("t1_kv_wait", {31'd0, b_key_valid}, 32'd0);
    busy_exp = 1'b0;
    step();
    chk("t1_kv_set", {31'd0, b_key_valid}, 32'd1);
    chk("t1_idle", {31'd0, b_ctrl_busy}, 32'd0);

    // Encryption with ciphertext_dv on the 12th cycle
    pt_req = 1'b1; busy_enc = 1'b1;
    step();
    chk("t2_start_enc", {31'd0, b_start_enc}, 32'd1);
    chk("t2_pt_ack", {31'd0, b_pt_ack}, 32'd1);
    pt_req = 1'b0;
    n_senc = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (b_start_enc) n_senc++;
    end
    chk("t2_blocks_wait", {16'd0, b_blocks}, 32'd0);
    chk("t2_busy_wait", {31'd0, b_ctrl_busy}, 32'd1);
    ciphertext_dv = 1'b1;
    step();
    ciphertext_dv = 1'b0; busy_enc = 1'b0;
    chk("t2_blocks", {16'd0, b_blocks}, 32'd1);
    chk("t2_idle", {31'd0, b_ctrl_busy}, 32'd0);
    chk("t2_one_start", n_senc, 32'd1);

    // Simultaneous key and plaintext requests
    step();
    key_req = 1'b1; key_len = 2'b00; pt_req = 1'b1;
    n_kack = 0; n_pack = 0; n_sexp = 0; n_senc = 0; t_exp = -1; t_enc = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (b_key_ack) begin n_kack++; key_req = 1'b0; end
      if (b_pt_ack) begin n_pack++; pt_req = 1'b0; end
      if (b_start_exp) begin n_sexp++; t_exp = i; end
      if (b_start_enc) begin n_senc++; t_enc = i; end
    end
    chk("t3_key_acks", n_kack, 32'd1);
    chk("t3_pt_acks", n_pack, 32'd1);
    chk("t3_start_exps", n_sexp, 32'd1);
    chk("t3_start_encs", n_senc, 32'd1);
    chk("t3_exp_first", {31'd0, (t_exp >= 0) && (t_exp < t_enc)}, 32'd1);
    chk("t3_kl128", {31'd0, b_kl128}, 32'd1);
    chk("t3_blocks", {16'd0, b_blocks}, 32'd2);
    chk("t3_kv", {31'd0, b_key_valid}, 32'd1);

    // Error cases
    do_reset();
    pt_req = 1'b1;
    step();
    chk("t4_pt_ack", {31'd0, b_pt_ack}, 32'd1);
    chk("t4_err", {31'd0, b_err}, 32'd1);
    chk("t4_code_nokey", {30'd0, b_err_code}, 32'd2);
    chk("t4_no_start", {31'd0, b_start_enc}, 32'd0);
    pt_req = 1'b0;
    step();
    chk("t4_err_pulse", {31'd0, b_err}, 32'd0);
    chk("t4_code_sticky", {30'd0, b_err_code}, 32'd2);
    chk("t4_ack_pulse", {31'd0, b_pt_ack}, 32'd0);
    key_req = 1'b1; key_len = 2'b11;
    step();
    chk("t4_key_ack", {31'd0, b_key_ack}, 32'd1);
    chk("t4_err2", {31'd0, b_err}, 32'd1);
    chk("t4_code_len", {30'd0, b_err_code}, 32'd1);
    chk("t4_no_exp", {31'd0, b_start_exp}, 32'd0);
    chk("t4_kl_kept", {29'd0, b_kl256, b_kl192, b_kl128}, 32'd1);
    chk("t4_kv_kept", {31'd0, b_key_valid}, 32'd0);
    key_req = 1'b0;
    step();
    chk("t4_single_ack", {31'd0, b_key_ack}, 32'd0);
    chk("t4_idle", {31'd0, b_ctrl_busy}, 32'd0);

    // Watchdog on the TIMEOUT=8 instance
    do_reset();
    sel = 1'b1;
    do_key(2'b01);
    chk("t5_kl192", {31'd0, s_kl192}, 32'd1);
    chk("t5_kv", {31'd0, s_key_valid}, 32'd1);
    pt_req = 1'b1; busy_enc = 1'b1;
    step();
    chk("t5_start_enc", {31'd0, s_start_enc}, 32'd1);
    pt_req = 1'b0;
    step(); step();
    for (int i = 0; i < 7; i++) step();
    chk("t5_no_err_yet", {31'd0, s_err}, 32'd0);
    chk("t5_still_busy", {31'd0, s_ctrl_busy}, 32'd1);
    step();
    chk("t5_err", {31'd0, s_err}, 32'd1);
    chk("t5_code_to", {30'd0, s_err_code}, 32'd3);
    chk("t5_kv_clr", {31'd0, s_key_valid}, 32'd0);
    chk("t5_idle", {31'd0, s_ctrl_busy}, 32'd0);
    chk("t5_blocks", {30'd0, s_blocks}, 32'd0);

    // Reset in the middle of ENC_WAIT
    do_key(2'b01);
    pt_req = 1'b1;
    step();
    pt_req = 1'b0;
    step(); step(); step();
    chk("t5_mid_busy", {31'd0, s_ctrl_busy}, 32'd1);
    arst_n = 1'b0;
    step();
    chk("t5r_busy", {31'd0, s_ctrl_busy}, 32'd0);
    chk("t5r_kv", {31'd0, s_key_valid}, 32'd0);
    chk("t5r_kl", {29'd0, s_kl256, s_kl192, s_kl128}, 32'd1);
    chk("t5r_code", {30'd0, s_err_code}, 32'd0);
    chk("t5r_err", {31'd0, s_err}, 32'd0);
    arst_n = 1'b1; busy_enc = 1'b0;

    // blocks_done wrap with CNT_W=2
    do_key(2'b00);
    for (int k = 0; k < 5; k++) begin
      do_enc();
      chk("t6_blocks", {30'd0, s_blocks}, {30'd0, seq[k]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
